// File: rtl/result_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_formatter
// Brief    : Signed result to packed-BCD magnitude/sign/error for the display
//            driver, using a bit-serial double-dabble. Optional hex bypass is
//            enabled with macro RESULT_BCD_HEX_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module result_bcd_formatter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_error,
    input  logic                    i_valid,
`ifdef RESULT_BCD_HEX_BYPASS_EN
    input  logic                    i_hex_mode,
`endif
    output logic                    o_ready,
    output logic [4*NUM_DIGITS-1:0] o_data,
    output logic                    o_error,
    output logic                    o_data_is_neg,
    output logic                    o_valid,
    input  logic                    i_ready
);

    // Decimal digits of 2^DATA_WIDTH-1: floor(DATA_WIDTH*log10(2)) + 1
    localparam int INT_DIGITS = (DATA_WIDTH * 30103) / 100000 + 1;
    localparam int BCD_W      = 4 * INT_DIGITS;
    localparam int OUT_W      = 4 * NUM_DIGITS;
    localparam int HEX_W      = 4 * ((DATA_WIDTH + 3) / 4);
    localparam int MAX_A      = (BCD_W > OUT_W) ? BCD_W : OUT_W;
    localparam int EXT_W      = (MAX_A > HEX_W) ? MAX_A : HEX_W;
    localparam int EXT_DIGITS = EXT_W / 4;
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_CHECK   = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_mag;
    logic [BCD_W-1:0]        r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_neg;
    logic                    r_hex;
    logic                    w_hex_in;
    logic                    w_neg_in;
    logic                    w_last;
    logic [BCD_W-1:0]        w_bcd_adj;
    logic [EXT_W-1:0]        w_ext;
    logic                    w_ovf;
    int                      w_allowed;

`ifdef RESULT_BCD_HEX_BYPASS_EN
    assign w_hex_in = i_hex_mode;
`else
    assign w_hex_in = 1'b0;
`endif

    assign w_neg_in = i_data[DATA_WIDTH-1] && !i_error;
    assign w_last   = (r_cnt == CNT_W'(DATA_WIDTH - 1));
    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_OUTPUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    if (i_error)       w_next = S_OUTPUT;
                    else if (w_hex_in) w_next = S_CHECK;
                    else               w_next = S_CONVERT;
                end
            end
            S_CONVERT: if (w_last) w_next = S_CHECK;
            S_CHECK:   w_next = S_OUTPUT;
            S_OUTPUT:  if (i_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Add-3 correction applied to every digit before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Digit source for the range check; the sign takes the top digit when negative
    always_comb begin
        w_ext = '0;
        if (r_hex) w_ext[DATA_WIDTH-1:0] = r_mag;
        else       w_ext[BCD_W-1:0]      = r_bcd;
        w_allowed = r_neg ? (NUM_DIGITS - 1) : NUM_DIGITS;
        w_ovf     = 1'b0;
        for (int i = 0; i < EXT_DIGITS; i++) begin
            if ((i >= w_allowed) && (w_ext[4*i +: 4] != 4'd0)) w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag         <= '0;
            r_bcd         <= '0;
            r_cnt         <= '0;
            r_neg         <= 1'b0;
            r_hex         <= 1'b0;
            o_data        <= '0;
            o_error       <= 1'b0;
            o_data_is_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_neg <= w_neg_in;
                        r_mag <= w_neg_in ? (-i_data) : i_data;
                        r_bcd <= '0;
                        r_cnt <= '0;
                        r_hex <= w_hex_in;
                        if (i_error) begin
                            o_error       <= 1'b1;
                            o_data        <= '0;
                            o_data_is_neg <= 1'b0;
                        end
                    end
                end
                S_CONVERT: begin
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_mag[DATA_WIDTH-1]};
                    r_mag <= r_mag << 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_CHECK: begin
                    if (w_ovf) begin
                        o_error       <= 1'b1;
                        o_data        <= '0;
                        o_data_is_neg <= 1'b0;
                    end else begin
                        o_error       <= 1'b0;
                        o_data        <= w_ext[OUT_W-1:0];
                        o_data_is_neg <= r_neg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_bcd_formatter
// Brief    : Directed self-checking bench; a 5-digit and a 4-digit instance
//            share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_bcd_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_data;
    logic        i_error;
    logic        i_valid;
    logic        i_ready;

    logic        o_ready5, o_error5, o_neg5, o_valid5;
    logic [19:0] o_data5;
    logic        o_ready4, o_error4, o_neg4, o_valid4;
    logic [15:0] o_data4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] cap_data5;
    logic        cap_neg5, cap_err5;
    logic [15:0] cap_data4;
    logic        cap_neg4, cap_err4;

    always #5 clk = ~clk;

    result_bcd_formatter #(.DATA_WIDTH(16), .NUM_DIGITS(5)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_error(i_error), .i_valid(i_valid),
        .o_ready(o_ready5), .o_data(o_data5), .o_error(o_error5),
        .o_data_is_neg(o_neg5), .o_valid(o_valid5), .i_ready(i_ready)
    );

    result_bcd_formatter #(.DATA_WIDTH(16), .NUM_DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .i_data(i_data), .i_error(i_error), .i_valid(i_valid),
        .o_ready(o_ready4), .o_data(o_data4), .o_error(o_error4),
        .o_data_is_neg(o_neg4), .o_valid(o_valid4), .i_ready(i_ready)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [19:0] x5;
        logic        n5;
        logic        e5;
        logic [15:0] x4;
        logic        n4;
        logic        e4;
    } vec_t;

    vec_t vecs [0:10] = '{
        '{16'h04D2, 20'h01234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0},  //  1234
        '{16'hFFFF, 20'h00001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0},  //  -1
        '{16'h8000, 20'h00000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1},  //  -32768
        '{16'h7FFF, 20'h32767, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1},  //  32767
        '{16'h0000, 20'h00000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0},  //  0
        '{16'h3039, 20'h12345, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1},  //  12345
        '{16'h270F, 20'h09999, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0},  //  9999
        '{16'hFC19, 20'h00999, 1'b1, 1'b0, 16'h0999, 1'b1, 1'b0},  //  -999
        '{16'hFC18, 20'h01000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1},  //  -1000
        '{16'hD8F1, 20'h09999, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1},  //  -9999
        '{16'hD8F0, 20'h00000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1}   //  -10000
    };

    // Full transaction with i_ready high; lat counts edges from accept to o_valid
    task automatic send(input logic [15:0] d, input logic e, output int lat);
        int waitc;
        waitc = 0;
        @(negedge clk);
        i_data = d; i_error = e; i_valid = 1'b1; i_ready = 1'b1;
        while (!(o_ready5 && o_ready4) && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        @(posedge clk);
        #1 i_valid = 1'b0;
        lat = 1;
        while (!o_valid5 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        cap_data5 = o_data5; cap_neg5 = o_neg5; cap_err5 = o_error5;
        cap_data4 = o_data4; cap_neg4 = o_neg4; cap_err4 = o_error4;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_error = 1'b0; i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_valid5, o_data5, o_error5, o_neg5} !== 23'd0 || {o_valid4, o_data4, o_error4, o_neg4} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b n=%b exp all zero", o_valid5, o_data5, o_error5, o_neg5);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (o_ready5 !== 1'b1 || o_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b/%b exp 1/1", o_ready5, o_ready4);
        end
    endtask

    task automatic test_decimal();
        int lat;
        for (int i = 0; i <= 10; i++) begin
            send(vecs[i].d, 1'b0, lat);
            n_checks++;
            if (lat !== 18 || cap_data5 !== vecs[i].x5 || cap_neg5 !== vecs[i].n5 || cap_err5 !== vecs[i].e5) begin
                n_fail++;
                $display("FAIL decimal5[%0d] in=%h got lat=%0d d=%h n=%b e=%b exp lat=18 d=%h n=%b e=%b",
                         i, vecs[i].d, lat, cap_data5, cap_neg5, cap_err5, vecs[i].x5, vecs[i].n5, vecs[i].e5);
            end
            n_checks++;
            if (cap_data4 !== vecs[i].x4 || cap_neg4 !== vecs[i].n4 || cap_err4 !== vecs[i].e4) begin
                n_fail++;
                $display("FAIL decimal4[%0d] in=%h got d=%h n=%b e=%b exp d=%h n=%b e=%b",
                         i, vecs[i].d, cap_data4, cap_neg4, cap_err4, vecs[i].x4, vecs[i].n4, vecs[i].e4);
            end
            n_checks++;
            if (o_valid5 !== 1'b0 || o_ready5 !== 1'b1) begin
                n_fail++;
                $display("FAIL decimal_handshake[%0d] got valid=%b ready=%b exp valid=0 ready=1", i, o_valid5, o_ready5);
            end
        end
    endtask

    task automatic test_error();
        int lat;
        logic [15:0] din [0:1] = '{16'h1234, 16'h8001};
        for (int i = 0; i < 2; i++) begin
            send(din[i], 1'b1, lat);
            n_checks++;
            if (lat !== 1 || cap_data5 !== 20'h0 || cap_err5 !== 1'b1 || cap_neg5 !== 1'b0
                || cap_data4 !== 16'h0 || cap_err4 !== 1'b1 || cap_neg4 !== 1'b0) begin
                n_fail++;
                $display("FAIL error_pass[%0d] got lat=%0d d=%h e=%b n=%b exp lat=1 d=0 e=1 n=0",
                         i, lat, cap_data5, cap_err5, cap_neg5);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        i_data = 16'h7FFF; i_error = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk);
        #1 i_valid = 1'b0;
        lat = 1;
        while (!o_valid5 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat !== 18) begin
            n_fail++;
            $display("FAIL bp_latency got %0d exp 18", lat);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            i_valid = 1'b1; i_data = 16'h0001;
            @(posedge clk);
            #1;
            n_checks++;
            if (o_valid5 !== 1'b1 || o_ready5 !== 1'b0 || o_data5 !== 20'h32767 || o_error5 !== 1'b0
                || o_neg5 !== 1'b0 || o_error4 !== 1'b1 || o_valid4 !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b r=%b d=%h e=%b n=%b e4=%b exp v=1 r=0 d=32767 e=0 n=0 e4=1",
                         c, o_valid5, o_ready5, o_data5, o_error5, o_neg5, o_error4);
            end
        end
        @(negedge clk);
        i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (o_valid5 !== 1'b0 || o_ready5 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", o_valid5, o_ready5);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_ready5 !== 1'b1 || o_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_accept got ready=%b/%b exp 1/1", o_ready5, o_ready4);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen_valid;
        @(negedge clk);
        i_data = 16'h1234; i_error = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (o_valid5 !== 1'b0 || o_ready5 !== 1'b1 || o_data5 !== 20'h0) begin
            n_fail++;
            $display("FAIL midreset_state got valid=%b ready=%b d=%h exp 0/1/0", o_valid5, o_ready5, o_data5);
        end
        seen_valid = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (o_valid5 || o_valid4) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_abandon got valid seen=%b exp 0", seen_valid);
        end
        send(16'h0000, 1'b0, lat);
        n_checks++;
        if (lat !== 18 || cap_data5 !== 20'h0 || cap_neg5 !== 1'b0 || cap_err5 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_zero got lat=%0d d=%h n=%b e=%b exp lat=18 d=0 n=0 e=0",
                     lat, cap_data5, cap_neg5, cap_err5);
        end
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_error();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
